jtkicker_romarb: RTL and testbench
==================================

Name: jtkicker_romarb

Overview:
- Three-requester SDRAM read scheduler for the kicker ROM path.
- Serves the main CPU ROM, the scroll GFX ROM and the object GFX ROM.
- Each requester slot has a one-entry tag/data cache; misses are arbitrated round-robin onto the single SDRAM read port.
- Sits between the game CPU/video blocks and the framework SDRAM controller, sharing the ROM bus while data is fetched in 2-word (32-bit) bursts.

Parameters:
- SLOT0_AW, 16, slot 0 (main CPU) address width.
- SLOT1_AW, 14, slot 1 (scroll) address width.
- SLOT2_AW, 14, slot 2 (object) address width.
- SLOT0_DW, 8, slot 0 data width (8, 16 or 32).
- SLOT1_DW, 32, slot 1 data width.
- SLOT2_DW, 32, slot 2 data width.
- SLOT0_OFFSET, 22'h0, slot 0 SDRAM word offset.
- SLOT1_OFFSET, 22'h0, slot 1 SDRAM word offset.
- SLOT2_OFFSET, 22'h0, slot 2 SDRAM word offset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- slotN_cs  in  1  request from slot N (N=0..2)
- slotN_addr  in  SLOTN_AW  address from slot N: byte address if DW=8, else 16-bit word address
- slotN_ok  out  1  slotN_dout valid for the current slotN_addr
- slotN_dout  out  SLOTN_DW  read data for slot N
- downloading  in  1  ROM download active
- sdram_req  out  1  read request to the SDRAM controller
- sdram_addr  out  22  SDRAM word address
- sdram_ack  in  1  request accepted
- data_dst  in  1  data_read carries a valid word this cycle
- data_rdy  in  1  last word of the burst (coincident with its data_dst)
- data_read  in  16  SDRAM read data

Behaviour:
- Reset values: all slotN_ok=0, slotN_dout=0, sdram_req=0, sdram_addr=0, cache valid bits=0, FSM=IDLE, round-robin pointer=slot 0.
- Word address per slot: wa = OFFSET + (DW==8 ? addr>>1 : addr). For DW=32, addr[0] is forced to 0.
- Cache per slot: tag = wa, 32-bit data, valid bit.
- Hit = cs & valid & tag==wa_current. slotN_ok = hit, combinational on addr/cs. There is no ok for a stale tag, so an address change drops ok in the same cycle.
- slotN_dout from cached data:
  - DW=32: {word1, word0}.
  - DW=16: word0.
  - DW=8: word0[15:8] if addr[0], else word0[7:0].
- Miss = cs & ~hit.
- FSM:
  - IDLE: if any miss, grant the first missing slot at or after the pointer (order 0,1,2, wrapping). Latch the grant index and wa, set sdram_req=1, sdram_addr=wa, go to REQ.
  - REQ: hold sdram_req and sdram_addr until sdram_ack. On the ack cycle clear sdram_req, go to WAIT.
  - WAIT: the first data_dst stores word0, go to WORD1.
  - WORD1: the next data_dst stores word1. At data_rdy, write the tag and set valid for the granted slot, set the pointer to grant+1 (mod 3), go to IDLE.
  - Data_dst cycles need not be consecutive.
- A hit is visible the cycle after data_rdy. Minimum miss latency is cs to ok = ack latency + burst + 1.
- Changing slot address or deasserting cs mid-burst: the burst completes and the cache fills with the latched wa (not the new address); the slot then re-arbitrates if it still misses.
- Simultaneous misses on all slots: serviced 0,1,2 from reset; thereafter strict round-robin, so no slot waits more than 2 other bursts.
- A data_dst arriving in IDLE or REQ is ignored.
- data_rdy in WAIT (single-word burst) stores word0, leaves word1 unchanged, completes the fill and returns to IDLE.
- downloading=1:
  - sdram_req forced 0 and FSM forced to IDLE within 1 cycle.
  - All valid bits cleared.
  - All ok=0.
  - Any in-flight burst is abandoned.
- Arbitration resumes the cycle after downloading falls.
- Reset mid-burst: same as reset values; later data_dst/data_rdy are ignored until a new grant.

Test Plan:
- Single miss: slot0_cs=1, addr=16'h0003, OFFSET0=0 → sdram_req with sdram_addr=22'h1. Ack, then dst words 16'hBEEF, 16'h1234 → slot0_ok the next cycle with dout=8'hBE. Addr 16'h0002 → dout=8'hEF with ok held (hit, no new sdram_req).
- 32-bit slot: slot1_addr=14'h0010, OFFSET1=22'h8000 → sdram_addr=22'h8010. Words 16'h5678, 16'h9ABC → slot1_dout=32'h9ABC5678.
- Fairness: all three cs misses at once → grants 0,1,2 in order. Slot 0 misses again during slot 1's burst → next grant is slot 2, then slot 0.
- Address change mid-burst: slot2 addr changes from 14'h20 to 14'h40 after ack → cache fills tag 14'h20, ok stays 0, a second request with sdram_addr=OFFSET2+14'h40 is issued.
- Download abort: downloading=1 during WORD1 → sdram_req=0, all ok=0. After downloading falls, the previously cached address misses again and re-requests.
- Stalled ack: sdram_ack held low for 20 cycles → sdram_req and sdram_addr stable for all 20 cycles; no ok asserted.

Source files
------------

// File: rtl/jtkicker_romarb.sv
// Three-slot ROM read scheduler: one-entry cache per slot, round-robin miss
// arbitration onto a single SDRAM read port fetching 2-word bursts.
module jtkicker_romarb #(
   parameter int unsigned SLOT0_AW     = 16,
   parameter int unsigned SLOT1_AW     = 14,
   parameter int unsigned SLOT2_AW     = 14,
   parameter int unsigned SLOT0_DW     = 8,
   parameter int unsigned SLOT1_DW     = 32,
   parameter int unsigned SLOT2_DW     = 32,
   parameter logic [21:0] SLOT0_OFFSET = 22'h0,
   parameter logic [21:0] SLOT1_OFFSET = 22'h0,
   parameter logic [21:0] SLOT2_OFFSET = 22'h0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                slot0_cs,
   input  logic [SLOT0_AW-1:0] slot0_addr,
   output logic                slot0_ok,
   output logic [SLOT0_DW-1:0] slot0_dout,
   input  logic                slot1_cs,
   input  logic [SLOT1_AW-1:0] slot1_addr,
   output logic                slot1_ok,
   output logic [SLOT1_DW-1:0] slot1_dout,
   input  logic                slot2_cs,
   input  logic [SLOT2_AW-1:0] slot2_addr,
   output logic                slot2_ok,
   output logic [SLOT2_DW-1:0] slot2_dout,
   input  logic                downloading,
   output logic                sdram_req,
   output logic [21:0]         sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_dst,
   input  logic                data_rdy,
   input  logic [15:0]         data_read
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WORD1} state_t;

   state_t      state, state_nx;
   logic [21:0] wa    [3];
   logic [21:0] tag   [3];
   logic [31:0] cdata [3];
   logic [2:0]  valid, cs_v, hit, miss;
   logic [1:0]  ptr, gnt, gnt_nx;
   logic [21:0] gnt_wa;
   logic [15:0] word0, word1;
   logic        grant_en, fill_en, found;
   logic [2:0]  s3;
   logic [1:0]  sel;

   function automatic logic [21:0] calc_wa(input logic [21:0] a, input int unsigned dw,
                                           input logic [21:0] off);
      logic [21:0] w;
      if (dw == 8)       w = a >> 1;
      else if (dw == 32) w = {a[21:1], 1'b0};
      else               w = a;
      return off + w;
   endfunction

   function automatic logic [31:0] sel_dout(input logic [31:0] d, input logic a0,
                                            input int unsigned dw);
      if (dw == 32)      return d;
      else if (dw == 16) return {16'd0, d[15:0]};
      else               return {24'd0, a0 ? d[15:8] : d[7:0]};
   endfunction

   assign wa[0] = calc_wa(22'(slot0_addr), SLOT0_DW, SLOT0_OFFSET);
   assign wa[1] = calc_wa(22'(slot1_addr), SLOT1_DW, SLOT1_OFFSET);
   assign wa[2] = calc_wa(22'(slot2_addr), SLOT2_DW, SLOT2_OFFSET);
   assign cs_v  = {slot2_cs, slot1_cs, slot0_cs};

   for (genvar i = 0; i < 3; i++) begin : g_hit
      assign hit[i]  = cs_v[i] & valid[i] & (tag[i] == wa[i]) & ~downloading;
      assign miss[i] = cs_v[i] & ~hit[i];
   end

   assign slot0_ok   = hit[0];
   assign slot1_ok   = hit[1];
   assign slot2_ok   = hit[2];
   assign slot0_dout = SLOT0_DW'(sel_dout(cdata[0], slot0_addr[0], SLOT0_DW));
   assign slot1_dout = SLOT1_DW'(sel_dout(cdata[1], slot1_addr[0], SLOT1_DW));
   assign slot2_dout = SLOT2_DW'(sel_dout(cdata[2], slot2_addr[0], SLOT2_DW));

   always_comb begin
      state_nx = state;
      grant_en = 1'b0;
      fill_en  = 1'b0;
      found    = 1'b0;
      gnt_nx   = '0;
      s3       = '0;
      sel      = '0;
      // first missing slot at or after the round-robin pointer
      for (int unsigned k = 0; k < 3; k++) begin
         s3 = {1'b0, ptr} + 3'(k);
         if (s3 >= 3'd3) s3 = s3 - 3'd3;
         sel = s3[1:0];
         if (!found && miss[sel]) begin
            found  = 1'b1;
            gnt_nx = sel;
         end
      end
      case (state)
         IDLE:  if (found) begin
                   grant_en = 1'b1;
                   state_nx = REQ;
                end
         REQ:   if (sdram_ack) state_nx = WAIT;
         WAIT:  if (data_dst && data_rdy) begin
                   fill_en  = 1'b1;
                   state_nx = IDLE;
                end else if (data_dst) begin
                   state_nx = WORD1;
                end
         WORD1: if (data_rdy) begin
                   fill_en  = 1'b1;
                   state_nx = IDLE;
                end
         default: state_nx = IDLE;
      endcase
      if (downloading) begin
         state_nx = IDLE;
         grant_en = 1'b0;
         fill_en  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         gnt        <= '0;
         gnt_wa     <= '0;
         word0      <= '0;
         word1      <= '0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         valid      <= '0;
         tag        <= '{default: '0};
         cdata      <= '{default: '0};
      end else begin
         state <= state_nx;
         if (grant_en) begin
            gnt        <= gnt_nx;
            gnt_wa     <= wa[gnt_nx];
            sdram_req  <= 1'b1;
            sdram_addr <= wa[gnt_nx];
         end
         if (state == REQ && sdram_ack) sdram_req <= 1'b0;
         if (state == WAIT && data_dst) word0 <= data_read;
         if (state == WORD1 && data_dst) word1 <= data_read;
         if (fill_en) begin
            valid[gnt] <= 1'b1;
            tag[gnt]   <= gnt_wa;
            // a burst ending in WAIT is single-word: keep the cached upper word
            if (state == WAIT) cdata[gnt] <= {cdata[gnt][31:16], data_read};
            else               cdata[gnt] <= {data_dst ? data_read : word1, word0};
            ptr <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
         end
         if (downloading) begin
            valid     <= '0;
            sdram_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Randomized self-checking bench for jtkicker_romarb against a slot-level cache model.
module tb_jtkicker_romarb;
   localparam logic [21:0] OFF1 = 22'h8000;
   localparam logic [21:0] OFF2 = 22'h10000;

   logic        clk = 1'b0, rst = 1'b1, downloading = 1'b0;
   logic        sdram_ack = 1'b0, data_dst = 1'b0, data_rdy = 1'b0;
   logic [15:0] data_read = '0;
   logic        cs_b [3];
   logic [15:0] addr_b [3];
   logic        ok0, ok1, ok2, sdram_req;
   logic [7:0]  dout0;
   logic [31:0] dout1, dout2;
   logic [21:0] sdram_addr;
   logic        ok_a [3];
   logic [31:0] dout_a [3];

   int checks = 0, errors = 0;
   bit          mv [3];
   logic [21:0] mtag [3];
   logic [31:0] mdata [3];
   int          mptr;

   always #5 clk = ~clk;

   jtkicker_romarb #(.SLOT1_OFFSET(OFF1), .SLOT2_OFFSET(OFF2)) dut (
      .clk(clk), .rst(rst),
      .slot0_cs(cs_b[0]), .slot0_addr(addr_b[0]), .slot0_ok(ok0), .slot0_dout(dout0),
      .slot1_cs(cs_b[1]), .slot1_addr(addr_b[1][13:0]), .slot1_ok(ok1), .slot1_dout(dout1),
      .slot2_cs(cs_b[2]), .slot2_addr(addr_b[2][13:0]), .slot2_ok(ok2), .slot2_dout(dout2),
      .downloading(downloading), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
      .sdram_ack(sdram_ack), .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read));

   always_comb begin
      ok_a[0] = ok0; ok_a[1] = ok1; ok_a[2] = ok2;
      dout_a[0] = {24'd0, dout0}; dout_a[1] = dout1; dout_a[2] = dout2;
   end

   function automatic logic [21:0] wa_m(input int s, input logic [15:0] a);
      if (s == 0) return {7'd0, a[15:1]};
      else if (s == 1) return OFF1 + {8'd0, a[13:1], 1'b0};
      else return OFF2 + {8'd0, a[13:1], 1'b0};
   endfunction

   function automatic bit cached(input int s);
      return mv[s] && mtag[s] == wa_m(s, addr_b[s]);
   endfunction

   function automatic bit exp_ok(input int s);
      return cs_b[s] && cached(s) && !downloading;
   endfunction

   function automatic logic [31:0] exp_dout(input int s);
      if (s != 0) return mdata[s];
      return addr_b[0][0] ? {24'd0, mdata[0][15:8]} : {24'd0, mdata[0][7:0]};
   endfunction

   function automatic int pick();
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (mptr + k) % 3;
         if (cs_b[s] && !cached(s)) return s;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin mv[s] = 0; mtag[s] = '0; mdata[s] = '0; end
      mptr = 0;
   endtask

   task automatic serve(input int slot, input int ack_dly, input bit single, input int chg,
                        input logic [15:0] chg_addr, input logic [15:0] w0, input logic [15:0] w1);
      logic [21:0] ea;
      int n;
      ea = wa_m(slot, addr_b[slot]);
      n = 0;
      while (sdram_req !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (sdram_req !== 1'b1) begin
         errors++; $display("FAIL req_timeout: sdram_req=%b expected 1 (slot%0d)", sdram_req, slot);
         return;
      end
      checks++;
      if (sdram_addr !== ea) begin
         errors++; $display("FAIL grant_addr: sdram_addr=%h expected %h (slot%0d)", sdram_addr, ea, slot);
      end
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk); #1;
         checks++;
         if (sdram_req !== 1'b1 || sdram_addr !== ea || ok_a[slot] !== 1'b0) begin
            errors++;
            $display("FAIL stall: req=%b addr=%h ok=%b expected 1 %h 0", sdram_req, sdram_addr, ok_a[slot], ea);
         end
      end
      @(negedge clk); sdram_ack = 1;
      @(negedge clk); sdram_ack = 0;
      if (chg >= 0) addr_b[chg] = chg_addr;
      #1; checks++;
      if (sdram_req !== 1'b0) begin
         errors++; $display("FAIL req_clear: sdram_req=%b expected 0", sdram_req);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk); data_dst = 1; data_read = w0; data_rdy = single;
      if (!single) begin
         repeat ($urandom_range(0, 2)) begin @(negedge clk); data_dst = 0; end
         @(negedge clk); data_dst = 1; data_read = w1; data_rdy = 1;
      end
      @(negedge clk); data_dst = 0; data_rdy = 0;
      mv[slot] = 1; mtag[slot] = ea;
      mdata[slot] = single ? {mdata[slot][31:16], w0} : {w1, w0};
      mptr = (slot + 1) % 3;
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (ok_a[s] !== exp_ok(s) || (exp_ok(s) && dout_a[s] !== exp_dout(s))) begin
            errors++;
            $display("FAIL fill slot%0d: ok=%b dout=%h expected ok=%b dout=%h", s, ok_a[s], dout_a[s], exp_ok(s), exp_dout(s));
         end
      end
   endtask

   task automatic test_reset();
      cs_b[0] = 1; addr_b[0] = 16'h0007;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin
         errors++; $display("FAIL reset_sdram: req=%b addr=%h expected 0 0", sdram_req, sdram_addr);
      end
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (ok_a[s] !== 1'b0 || dout_a[s] !== 32'h0) begin
            errors++; $display("FAIL reset_slot%0d: ok=%b dout=%h expected 0 0", s, ok_a[s], dout_a[s]);
         end
      end
      @(negedge clk); rst = 0; cs_b[0] = 0; model_reset();
   endtask

   task automatic test_single_miss();
      @(negedge clk); cs_b[0] = 1; addr_b[0] = 16'h0003; #1;
      checks++;
      if (ok0 !== 1'b0) begin errors++; $display("FAIL miss_ok: ok0=%b expected 0", ok0); end
      serve(0, 1, 0, -1, '0, 16'hBEEF, 16'h1234);
      checks++;
      if (ok0 !== 1'b1 || dout0 !== 8'hBE || sdram_addr !== 22'h1) begin
         errors++; $display("FAIL single_miss: ok=%b dout=%h addr=%h expected 1 be 000001", ok0, dout0, sdram_addr);
      end
      @(negedge clk); addr_b[0] = 16'h0002; #1;
      checks++;
      if (ok0 !== 1'b1 || dout0 !== 8'hEF) begin
         errors++; $display("FAIL low_byte: ok=%b dout=%h expected 1 ef", ok0, dout0);
      end
      repeat (3) begin
         @(negedge clk); #1; checks++;
         if (sdram_req !== 1'b0) begin errors++; $display("FAIL hit_no_req: sdram_req=%b expected 0", sdram_req); end
      end
      @(negedge clk); cs_b[0] = 0; #1; checks++;
      if (ok0 !== 1'b0) begin errors++; $display("FAIL cs_low: ok0=%b expected 0", ok0); end
   endtask

   task automatic test_wide_slot();
      @(negedge clk); cs_b[1] = 1; addr_b[1] = 16'h0010; #1;
      serve(1, 2, 0, -1, '0, 16'h5678, 16'h9ABC);
      checks++;
      if (ok1 !== 1'b1 || dout1 !== 32'h9ABC5678 || sdram_addr !== 22'h8010) begin
         errors++; $display("FAIL wide_slot: ok=%b dout=%h addr=%h expected 1 9abc5678 008010", ok1, dout1, sdram_addr);
      end
      @(negedge clk); addr_b[1] = 16'h0020; #1;
      serve(1, 0, 1, -1, '0, 16'h1111, 16'h0);
      checks++;
      if (ok1 !== 1'b1 || dout1 !== 32'h9ABC1111) begin
         errors++; $display("FAIL single_word: ok=%b dout=%h expected 1 9abc1111", ok1, dout1);
      end
      @(negedge clk); cs_b[1] = 0;
   endtask

   task automatic test_stall();
      @(negedge clk); cs_b[2] = 1; addr_b[2] = 16'h0100; #1;
      serve(2, 20, 0, -1, '0, 16'(($urandom)), 16'($urandom));
      @(negedge clk); cs_b[2] = 0;
   endtask

   task automatic test_fairness();
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0; model_reset();
      cs_b[0] = 1; addr_b[0] = 16'h0040;
      cs_b[1] = 1; addr_b[1] = 16'h0030;
      cs_b[2] = 1; addr_b[2] = 16'h0050; #1;
      serve(0, 0, 0, -1, '0, 16'h0A0A, 16'h0B0B);
      serve(1, 1, 0, 0, 16'h0080, 16'h1A1A, 16'h1B1B);
      serve(2, 0, 0, -1, '0, 16'h2A2A, 16'h2B2B);
      serve(0, 0, 0, -1, '0, 16'h3A3A, 16'h3B3B);
      repeat (3) begin
         @(negedge clk); #1; checks++;
         if (sdram_req !== 1'b0 || ok0 !== 1'b1 || ok1 !== 1'b1 || ok2 !== 1'b1) begin
            errors++; $display("FAIL fair_settle: req=%b ok=%b%b%b expected 0 111", sdram_req, ok0, ok1, ok2);
         end
      end
      @(negedge clk); cs_b[0] = 0; cs_b[1] = 0; cs_b[2] = 0;
   endtask

   task automatic test_addr_change();
      @(negedge clk); cs_b[2] = 1; addr_b[2] = 16'h0020; #1;
      serve(2, 1, 0, 2, 16'h0040, 16'hC0DE, 16'hCAFE);
      checks++;
      if (ok2 !== 1'b0) begin errors++; $display("FAIL stale_ok: ok2=%b expected 0", ok2); end
      serve(2, 0, 0, -1, '0, 16'h4444, 16'h5555);
      checks++;
      if (sdram_addr !== 22'h10040 || ok2 !== 1'b1 || dout2 !== 32'h55554444) begin
         errors++; $display("FAIL rerequest: addr=%h ok=%b dout=%h expected 010040 1 55554444", sdram_addr, ok2, dout2);
      end
      @(negedge clk); cs_b[2] = 0;
   endtask

   task automatic test_download();
      int n;
      @(negedge clk); cs_b[0] = 1; addr_b[0] = 16'h0080; cs_b[1] = 1; addr_b[1] = 16'h0200; #1;
      checks++;
      if (ok0 !== 1'b1) begin errors++; $display("FAIL pre_dl_hit: ok0=%b expected 1", ok0); end
      n = 0;
      while (sdram_req !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 22'h8200) begin
         errors++; $display("FAIL dl_req: req=%b addr=%h expected 1 008200", sdram_req, sdram_addr);
      end
      @(negedge clk); sdram_ack = 1;
      @(negedge clk); sdram_ack = 0;
      @(negedge clk); data_dst = 1; data_read = 16'h7777;
      @(negedge clk); data_dst = 0; downloading = 1; #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (ok_a[s] !== 1'b0) begin errors++; $display("FAIL dl_ok slot%0d: ok=%b expected 0", s, ok_a[s]); end
      end
      @(negedge clk); data_dst = 1; data_rdy = 1; data_read = 16'h8888; #1;
      checks++;
      if (sdram_req !== 1'b0) begin errors++; $display("FAIL dl_req_low: sdram_req=%b expected 0", sdram_req); end
      @(negedge clk); data_dst = 0; data_rdy = 0;
      @(negedge clk); downloading = 0;
      for (int s = 0; s < 3; s++) mv[s] = 0;
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (ok_a[s] !== 1'b0) begin errors++; $display("FAIL post_dl_ok slot%0d: ok=%b expected 0", s, ok_a[s]); end
      end
      n = 0;
      while (pick() >= 0 && n < 4) begin serve(pick(), 0, 0, -1, '0, 16'($urandom), 16'($urandom)); n++; end
      checks++;
      if (ok0 !== 1'b1 || ok1 !== 1'b1) begin errors++; $display("FAIL post_dl_refill: ok=%b%b expected 11", ok0, ok1); end
      @(negedge clk); cs_b[0] = 0; cs_b[1] = 0;
   endtask

   task automatic test_reset_midburst();
      int n;
      @(negedge clk); cs_b[2] = 1; addr_b[2] = 16'h0300; #1;
      n = 0;
      while (sdram_req !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      @(negedge clk); sdram_ack = 1;
      @(negedge clk); sdram_ack = 0;
      @(negedge clk); data_dst = 1; data_read = 16'h9999;
      @(negedge clk); data_dst = 0; rst = 1;
      @(negedge clk); rst = 0; data_dst = 1; data_rdy = 1; data_read = 16'hAAAA; model_reset();
      @(negedge clk); data_dst = 0; data_rdy = 0; #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (ok_a[s] !== 1'b0) begin errors++; $display("FAIL rst_burst slot%0d: ok=%b expected 0", s, ok_a[s]); end
      end
      serve(2, 1, 0, -1, '0, 16'hD00D, 16'hF00D);
      @(negedge clk); cs_b[2] = 0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int n;
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            cs_b[s] = ($urandom_range(0, 3) != 0);
            addr_b[s] = 16'($urandom_range(0, 7));
         end
         #1;
         for (int s = 0; s < 3; s++) begin
            checks++;
            if (ok_a[s] !== exp_ok(s) || (exp_ok(s) && dout_a[s] !== exp_dout(s))) begin
               errors++;
               $display("FAIL rand_pre slot%0d: ok=%b dout=%h expected ok=%b dout=%h", s, ok_a[s], dout_a[s], exp_ok(s), exp_dout(s));
            end
         end
         n = 0;
         while (pick() >= 0 && n < 5) begin
            serve(pick(), $urandom_range(0, 3), ($urandom_range(0, 4) == 0), -1, '0, 16'($urandom), 16'($urandom));
            n++;
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin cs_b[s] = 0; addr_b[s] = '0; end
      model_reset();
      test_reset();
      test_single_miss();
      test_wide_slot();
      test_stall();
      test_fairness();
      test_addr_change();
      test_download();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
